// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter: round-robin grant between the instruction
// and data refill ports, one AR transaction outstanding at a time, R beats
// steered back to the owner, and flushed instruction refills drained silently.
//
// Request handshake: a requester holds *_req_valid, addr and len stable until
// it sees *_req_ready high in the same cycle; that cycle is the transfer.
// AXI AR/R follow the standard valid/ready rule: a transfer happens in a
// cycle where valid and ready are both high, and valid plus payload stay
// stable until then. Response ports show a beat only in the cycle it is
// handshaken on R (i side has no backpressure, d side via d_resp_ready).
module axi_read_arbiter #(
  parameter logic [3:0] ID_I   = 4'h0,
  parameter logic [3:0] ID_D   = 4'h1,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [7:0]        i_req_len,
  output logic              i_req_ready,
  input  logic              i_flush,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  output logic              i_resp_last,
  output logic              i_resp_err,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [7:0]        d_req_len,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              d_resp_last,
  output logic              d_resp_err,
  input  logic              d_resp_ready,
  output logic [3:0]        s_axi_arid,
  output logic [ADDR_W-1:0] s_axi_araddr,
  output logic [7:0]        s_axi_arlen,
  output logic [2:0]        s_axi_arsize,
  output logic [1:0]        s_axi_arburst,
  output logic              s_axi_arvalid,
  input  logic              s_axi_arready,
  input  logic [3:0]        s_axi_rid,
  input  logic [DATA_W-1:0] s_axi_rdata,
  input  logic [1:0]        s_axi_rresp,
  input  logic              s_axi_rlast,
  input  logic              s_axi_rvalid,
  output logic              s_axi_rready,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_DATA  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic                owner_d;       // 1: data side owns the channel
  logic                last_grant_d;  // 1: most recent grant went to data side
  logic                flush_flag;    // flush seen while I request sat in ADDR
  logic [ADDR_W-1:0]   lat_addr;
  logic [7:0]          lat_len;
  logic [3:0]          lat_id;
  logic [7:0]          cnt;

  logic i_ok, grant_i, grant_d, flush_now, rd_rready, r_hs, ar_hs, beat_err;

  // A flushed I request is never granted; ties alternate against last_grant.
  assign i_ok      = i_req_valid & ~i_flush;
  assign grant_i   = i_ok & (~d_req_valid | last_grant_d);
  assign grant_d   = d_req_valid & (~i_ok | ~last_grant_d);
  assign flush_now = ~owner_d & i_flush;
  assign rd_rready = (state == S_DRAIN) |
                     ((state == S_DATA) & (~owner_d | d_resp_ready));
  assign r_hs      = s_axi_rvalid & rd_rready;
  assign ar_hs     = (state == S_ADDR) & s_axi_arready;
  assign beat_err  = (s_axi_rresp != 2'b00) | (s_axi_rid != lat_id) |
                     (s_axi_rlast & (cnt != lat_len)) |
                     (~s_axi_rlast & (cnt == lat_len));

  assign s_axi_arsize  = 3'b010;
  assign s_axi_arburst = 2'b01;
  assign s_axi_arid    = lat_id;
  assign s_axi_araddr  = lat_addr;
  assign s_axi_arlen   = lat_len;
  assign s_axi_rready  = rd_rready;
  assign dbg_state     = state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_i | grant_d) state_nxt = S_ADDR;
      S_ADDR:  if (ar_hs) state_nxt = (flush_flag | flush_now) ? S_DRAIN : S_DATA;
      S_DATA: begin
        if (r_hs & s_axi_rlast) state_nxt = S_IDLE;
        else if (flush_now)     state_nxt = S_DRAIN;
      end
      S_DRAIN: if (r_hs & s_axi_rlast) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: request readies in IDLE, AR valid in ADDR, beat steering in DATA.
  always_comb begin
    i_req_ready   = 1'b0;
    d_req_ready   = 1'b0;
    s_axi_arvalid = 1'b0;
    i_resp_valid  = 1'b0;
    d_resp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        i_req_ready = grant_i;
        d_req_ready = grant_d;
      end
      S_ADDR: s_axi_arvalid = 1'b1;
      S_DATA: begin
        if (r_hs) begin
          if (owner_d)        d_resp_valid = 1'b1;
          else if (!i_flush)  i_resp_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Response payloads are zero whenever the beat is not being presented.
  always_comb begin
    i_resp_data = i_resp_valid ? s_axi_rdata : '0;
    i_resp_last = i_resp_valid & s_axi_rlast;
    i_resp_err  = i_resp_valid & beat_err;
    d_resp_data = d_resp_valid ? s_axi_rdata : '0;
    d_resp_last = d_resp_valid & s_axi_rlast;
    d_resp_err  = d_resp_valid & beat_err;
  end

  // Grant bookkeeping, latched request fields, beat counter and flush flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_d      <= 1'b0;
      last_grant_d <= 1'b0;
      flush_flag   <= 1'b0;
      lat_addr     <= '0;
      lat_len      <= '0;
      lat_id       <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_i | grant_d) begin
            owner_d      <= grant_d;
            last_grant_d <= grant_d;
            lat_addr     <= grant_d ? d_req_addr : i_req_addr;
            lat_len      <= grant_d ? d_req_len : i_req_len;
            lat_id       <= grant_d ? ID_D : ID_I;
            cnt          <= '0;
            flush_flag   <= 1'b0;
          end
        end
        S_ADDR: if (flush_now) flush_flag <= 1'b1;
        S_DATA, S_DRAIN: begin
          if (r_hs) begin
            if (s_axi_rlast) begin
              cnt        <= '0;
              flush_flag <= 1'b0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: acts as both requesters and the AXI slave.
// Beats expected on a response port are queued when driven on R and checked
// by a monitor when the DUT presents them.
module tb_axi_read_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [3:0] IDI = 4'h0;
  localparam logic [3:0] IDD = 4'h1;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_valid, i_req_ready, i_flush;
  logic [AW-1:0] i_req_addr;
  logic [7:0]    i_req_len;
  logic          i_resp_valid, i_resp_last, i_resp_err;
  logic [DW-1:0] i_resp_data;
  logic          d_req_valid, d_req_ready;
  logic [AW-1:0] d_req_addr;
  logic [7:0]    d_req_len;
  logic          d_resp_valid, d_resp_last, d_resp_err, d_resp_ready;
  logic [DW-1:0] d_resp_data;
  logic [3:0]    s_axi_arid, s_axi_rid;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0]    s_axi_arlen;
  logic [2:0]    s_axi_arsize;
  logic [1:0]    s_axi_arburst, s_axi_rresp, dbg_state;
  logic          s_axi_arvalid, s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_rdata;

  int checks = 0;
  int errors = 0;
  // entry = {side(0=i,1=d), data, last, err}
  logic [DW+2:0] exp_q[$];

  axi_read_arbiter #(.ID_I(IDI), .ID_D(IDD), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_len(i_req_len),
    .i_req_ready(i_req_ready), .i_flush(i_flush),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .i_resp_last(i_resp_last), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_len(d_req_len),
    .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .d_resp_last(d_resp_last), .d_resp_err(d_resp_err), .d_resp_ready(d_resp_ready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  // Scoreboard monitor: every presented beat must match the queue head.
  always @(negedge clk) begin
    logic [DW+2:0] got, exp;
    if (rst === 1'b1 && (i_resp_valid === 1'b1 || (d_resp_valid === 1'b1 && d_resp_ready === 1'b1))) begin
      got = (i_resp_valid === 1'b1) ? {1'b0, i_resp_data, i_resp_last, i_resp_err}
                                    : {1'b1, d_resp_data, d_resp_last, d_resp_err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got=%h expected=no_beat", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL resp_beat got=%h expected=%h", got, exp);
        end
      end
    end
  end

  // Raise a request and wait (bounded) for its ready; ends at posedge+1.
  task automatic issue_req(input bit side, input logic [AW-1:0] addr, input logic [7:0] len);
    int n;
    if (side) begin d_req_valid = 1'b1; d_req_addr = addr; d_req_len = len; end
    else      begin i_req_valid = 1'b1; i_req_addr = addr; i_req_len = len; end
    n = 0;
    @(negedge clk);
    while ((side ? d_req_ready : i_req_ready) !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((side ? d_req_ready : i_req_ready) !== 1'b1) begin
      errors++;
      $display("FAIL req_ready side=%0d got=0 expected=1", side);
    end
    @(posedge clk); #1;
    if (side) d_req_valid = 1'b0; else i_req_valid = 1'b0;
  endtask

  // AR slave: expects arvalid one cycle after the grant, stalls 'delay'
  // cycles (optionally pulsing i_flush on stall cycle flush_cyc), then accepts.
  task automatic ar_accept(input logic [3:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input int delay, input int flush_cyc);
    @(negedge clk);
    checks++;
    if (s_axi_arvalid !== 1'b1 || s_axi_arid !== id || s_axi_araddr !== addr || s_axi_arlen !== len) begin
      errors++;
      $display("FAIL ar_first got=%b/%h/%h/%h expected=1/%h/%h/%h",
               s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, id, addr, len);
    end
    for (int k = 0; k < delay; k++) begin
      @(posedge clk); #1;
      i_flush = (k == flush_cyc);
      @(negedge clk);
      checks++;
      if (s_axi_arvalid !== 1'b1 || s_axi_arid !== id || s_axi_araddr !== addr || s_axi_arlen !== len) begin
        errors++;
        $display("FAIL ar_hold cyc=%0d got=%b/%h/%h/%h expected=1/%h/%h/%h", k,
                 s_axi_arvalid, s_axi_arid, s_axi_araddr, s_axi_arlen, id, addr, len);
      end
    end
    @(posedge clk); #1;
    i_flush = 1'b0;
    s_axi_arready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axi_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL ar_handshake got=%b expected=1", s_axi_arvalid);
    end
    @(posedge clk); #1;
    s_axi_arready = 1'b0;
  endtask

  // R slave: n beats, last on beat n-1. Beats from flush_beat on (or all,
  // when drained) must not be delivered. Expected err comes from the beat
  // position versus len and the rresp driven.
  task automatic send_burst(input logic [3:0] id, input bit side, input int n, input int len,
                            input int err_beat, input int flush_beat, input bit drained,
                            input bit toggle);
    for (int k = 0; k < n; k++) begin
      logic last, err, deliver, exp_rr;
      int w;
      last    = (k == n - 1);
      deliver = !drained && (flush_beat < 0 || k < flush_beat);
      err     = (k == err_beat) || (last && k != len) || (!last && k == len);
      s_axi_rvalid = 1'b1;
      s_axi_rid    = id;
      s_axi_rdata  = $urandom;
      s_axi_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      s_axi_rlast  = last;
      i_flush      = (k == flush_beat);
      if (deliver) exp_q.push_back({side, s_axi_rdata, last, err});
      w = 0;
      forever begin
        @(negedge clk);
        exp_rr = (side && deliver) ? d_resp_ready : 1'b1;
        checks++;
        if (s_axi_rready !== exp_rr) begin
          errors++;
          $display("FAIL rready beat=%0d got=%b expected=%b", k, s_axi_rready, exp_rr);
        end
        if (!deliver && (i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0)) begin
          errors++;
          $display("FAIL drain_silent beat=%0d got=%b%b expected=00", k, i_resp_valid, d_resp_valid);
        end
        if (s_axi_rready === 1'b1 || w >= 20) break;
        @(posedge clk); #1;
        if (toggle) d_resp_ready = ~d_resp_ready;
        w++;
      end
      @(posedge clk); #1;
      i_flush = 1'b0;
      if (toggle) d_resp_ready = ~d_resp_ready;
    end
    s_axi_rvalid = 1'b0;
    s_axi_rlast  = 1'b0;
    s_axi_rresp  = 2'b00;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_%s got=state%0d/q%0d expected=state0/q0", tag, dbg_state, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0 || s_axi_arvalid !== 1'b0 ||
        s_axi_rready !== 1'b0 || i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0 ||
        s_axi_arid !== 4'h0 || s_axi_araddr !== '0 || s_axi_arlen !== 8'h0 ||
        s_axi_arsize !== 3'b010 || s_axi_arburst !== 2'b01 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b%b size=%b burst=%b st=%0d expected=0000 size=010 burst=01 st=0",
               i_req_ready, d_req_ready, s_axi_arvalid, s_axi_rready, s_axi_arsize, s_axi_arburst, dbg_state);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_single_i();
    issue_req(1'b0, 32'h1FC0_0000, 8'd7);
    ar_accept(IDI, 32'h1FC0_0000, 8'd7, 2, -1);
    send_burst(IDI, 1'b0, 8, 7, -1, -1, 1'b0, 1'b0);
    check_idle("single_i");
  endtask

  task automatic test_round_robin();
    // Simultaneous pair after reset history with last grant on I: D first.
    i_req_valid = 1'b1; i_req_addr = 32'h0000_1000; i_req_len = 8'd1;
    d_req_valid = 1'b1; d_req_addr = 32'h0000_2000; d_req_len = 8'd1;
    @(negedge clk);
    checks++;
    if (d_req_ready !== 1'b1 || i_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rr_first got=i%b/d%b expected=i0/d1", i_req_ready, d_req_ready);
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    ar_accept(IDD, 32'h0000_2000, 8'd1, 0, -1);
    send_burst(IDD, 1'b1, 2, 1, -1, -1, 1'b0, 1'b0);
    // I still pending and D asks again: I wins the cycle right after rlast.
    d_req_valid = 1'b1; d_req_addr = 32'h0000_3000; d_req_len = 8'd0;
    @(negedge clk);
    checks++;
    if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL rr_second got=i%b/d%b st%0d expected=i1/d0 st0", i_req_ready, d_req_ready, dbg_state);
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    ar_accept(IDI, 32'h0000_1000, 8'd1, 1, -1);
    send_burst(IDI, 1'b0, 2, 1, -1, -1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rr_third got=d%b expected=d1", d_req_ready);
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    ar_accept(IDD, 32'h0000_3000, 8'd0, 0, -1);
    send_burst(IDD, 1'b1, 1, 0, -1, -1, 1'b0, 1'b0);
    check_idle("rr");
  endtask

  task automatic test_backpressure();
    d_resp_ready = 1'b1;
    issue_req(1'b1, 32'h8000_0040, 8'd3);
    ar_accept(IDD, 32'h8000_0040, 8'd3, 0, -1);
    send_burst(IDD, 1'b1, 4, 3, -1, -1, 1'b0, 1'b1);
    d_resp_ready = 1'b1;
    check_idle("bp");
  endtask

  task automatic test_flush_data();
    issue_req(1'b0, 32'h0000_4000, 8'd7);
    ar_accept(IDI, 32'h0000_4000, 8'd7, 0, -1);
    send_burst(IDI, 1'b0, 8, 7, -1, 3, 1'b0, 1'b0);
    check_idle("flush_data");
    issue_req(1'b1, 32'h0000_5000, 8'd2);
    ar_accept(IDD, 32'h0000_5000, 8'd2, 0, -1);
    send_burst(IDD, 1'b1, 3, 2, -1, -1, 1'b0, 1'b0);
    check_idle("after_flush");
  endtask

  task automatic test_flush_addr();
    issue_req(1'b0, 32'h0000_6000, 8'd7);
    ar_accept(IDI, 32'h0000_6000, 8'd7, 3, 1);
    send_burst(IDI, 1'b0, 8, 7, -1, -1, 1'b1, 1'b0);
    check_idle("flush_addr");
  endtask

  task automatic test_errors();
    issue_req(1'b0, 32'h0000_7000, 8'd3);
    ar_accept(IDI, 32'h0000_7000, 8'd3, 0, -1);
    send_burst(IDI, 1'b0, 4, 3, 1, -1, 1'b0, 1'b0);
    check_idle("err_resp");
    issue_req(1'b1, 32'h0000_8000, 8'd3);
    ar_accept(IDD, 32'h0000_8000, 8'd3, 0, -1);
    send_burst(IDD, 1'b1, 3, 3, -1, -1, 1'b0, 1'b0);
    check_idle("err_early_last");
  endtask

  task automatic test_flush_idle_len0();
    i_req_valid = 1'b1; i_req_addr = 32'h0000_9000; i_req_len = 8'd0;
    i_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (i_req_ready !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL flush_blocks_grant got=%b st%0d expected=0 st0", i_req_ready, dbg_state);
    end
    @(posedge clk); #1;
    i_flush = 1'b0;
    issue_req(1'b0, 32'h0000_9000, 8'd0);
    ar_accept(IDI, 32'h0000_9000, 8'd0, $urandom_range(0, 2), -1);
    send_burst(IDI, 1'b0, 1, 0, -1, -1, 1'b0, 1'b0);
    check_idle("len0");
  endtask

  initial begin
    rst = 1'b0;
    i_req_valid = 1'b0; i_req_addr = '0; i_req_len = '0; i_flush = 1'b0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_len = '0; d_resp_ready = 1'b1;
    s_axi_arready = 1'b0; s_axi_rid = '0; s_axi_rdata = '0; s_axi_rresp = '0;
    s_axi_rlast = 1'b0; s_axi_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(posedge clk); #1;
    test_round_robin();
    test_single_i();
    test_backpressure();
    test_flush_data();
    test_flush_addr();
    test_errors();
    test_flush_idle_len0();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
